// File: rtl/dpad_analog_pkg.sv
// Shared types and default sizing for the D-pad/analog value generator.
// Mode encoding is the 2-bit per-channel field driven by the core's OSD settings.
package dpad_analog_pkg;

  typedef enum logic [1:0] {
    RM_ANALOG = 2'd0,
    RM_HOLD   = 2'd1,
    RM_SPRING = 2'd2,
    RM_RSVD   = 2'd3
  } ramp_mode_t;

  localparam int DEF_WIDTH    = 8;
  localparam int DEF_MAX_VAL  = 254;
  localparam int DEF_TICK_DIV = 196850;

endpackage

// File: rtl/dpad_analog_chan.sv
// One channel: analog passthrough with clamp, or D-pad ramp (hold / spring-return).
// Output registered, 1-cycle latency; ramp modes only move on tick, no backpressure.
module dpad_analog_chan
  import dpad_analog_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int STEP     = 1,
  parameter int MIN_VAL  = 0,
  parameter int MAX_VAL  = DEF_MAX_VAL,
  parameter int REST_VAL = 0
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic             tick,
  input  ramp_mode_t       mode,
  input  logic             invert,
  input  logic             inc,
  input  logic             dec,
  input  logic [WIDTH-1:0] analog,
  output logic [WIDTH-1:0] value,
  output logic             changed
);

  // Two guard bits keep +STEP and offset-binary sums from wrapping.
  localparam int XW = WIDTH + 2;
  typedef logic [XW-1:0] ext_t;

  localparam ext_t STEP_X = ext_t'(STEP);
  localparam ext_t MIN_X  = ext_t'(MIN_VAL);
  localparam ext_t MAX_X  = ext_t'(MAX_VAL);
  localparam ext_t REST_X = ext_t'(REST_VAL);
  localparam ext_t HALF_X = ext_t'(2 ** (WIDTH - 1));
  localparam ext_t FULL_X = ext_t'((2 ** WIDTH) - 1);

  ext_t cur;
  ext_t offs;
  ext_t ana_x;
  ext_t up_x;
  ext_t dn_x;
  ext_t spring_x;
  ext_t nxt;
  logic [WIDTH-1:0] value_next;

  always_comb begin
    cur  = {2'b00, value};
    offs = {{2{analog[WIDTH-1]}}, analog} + HALF_X;
    if (invert) begin
      offs = FULL_X - offs;
    end

    ana_x = offs;
    if (offs < MIN_X) begin
      ana_x = MIN_X;
    end else if (offs > MAX_X) begin
      ana_x = MAX_X;
    end

    up_x = cur + STEP_X;
    if (up_x > MAX_X) begin
      up_x = MAX_X;
    end
    dn_x = (cur < MIN_X + STEP_X) ? MIN_X : cur - STEP_X;

    // Snap to rest when closer than one step so the spring never overshoots.
    spring_x = REST_X;
    if (cur > REST_X) begin
      spring_x = (cur - REST_X < STEP_X) ? REST_X : cur - STEP_X;
    end else if (cur < REST_X) begin
      spring_x = (REST_X - cur < STEP_X) ? REST_X : cur + STEP_X;
    end

    nxt = cur;
    if (mode == RM_ANALOG) begin
      nxt = ana_x;
    end else if (tick) begin
      if (inc && !dec) begin
        nxt = up_x;
      end else if (dec && !inc) begin
        nxt = dn_x;
      end else if (!inc && !dec && mode == RM_SPRING) begin
        nxt = spring_x;
      end
    end
    value_next = nxt[WIDTH-1:0];
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      value   <= WIDTH'(REST_VAL);
      changed <= 1'b0;
    end else begin
      value   <= value_next;
      changed <= (value_next != value);
    end
  end

endmodule

// File: rtl/dpad_analog_ramp.sv
// Multi-channel controller-to-analog generator sharing one ramp prescaler.
// Per-channel 1-cycle registered output; purely level-driven, no backpressure.
module dpad_analog_ramp
  import dpad_analog_pkg::*;
#(
  parameter int CHANNELS = 2,
  parameter int WIDTH    = DEF_WIDTH,
  parameter int TICK_DIV = DEF_TICK_DIV,
  parameter int STEP     = 1,
  parameter int MIN_VAL  = 0,
  parameter int MAX_VAL  = DEF_MAX_VAL,
  parameter int REST_VAL = 0
) (
  input  logic                      clk_sys,
  input  logic                      reset,
  input  logic [2*CHANNELS-1:0]     mode,
  input  logic [CHANNELS-1:0]       invert,
  input  logic [CHANNELS-1:0]       inc,
  input  logic [CHANNELS-1:0]       dec,
  input  logic [CHANNELS*WIDTH-1:0] analog,
  output logic [CHANNELS*WIDTH-1:0] out_val,
  output logic [CHANNELS-1:0]       out_changed,
  output logic                      tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] count;

  // Gated by reset so the strobe reads low during reset even when TICK_DIV is 1.
  assign tick = (count == LAST) && !reset;

  always_ff @(posedge clk_sys) begin
    if (reset || count == LAST) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

  for (genvar n = 0; n < CHANNELS; n++) begin : g_chan
    dpad_analog_chan #(
      .WIDTH    (WIDTH),
      .STEP     (STEP),
      .MIN_VAL  (MIN_VAL),
      .MAX_VAL  (MAX_VAL),
      .REST_VAL (REST_VAL)
    ) u_chan (
      .clk_sys (clk_sys),
      .reset   (reset),
      .tick    (tick),
      .mode    (ramp_mode_t'(mode[2*n +: 2])),
      .invert  (invert[n]),
      .inc     (inc[n]),
      .dec     (dec[n]),
      .analog  (analog[n*WIDTH +: WIDTH]),
      .value   (out_val[n*WIDTH +: WIDTH]),
      .changed (out_changed[n])
    );
  end

endmodule

// File: tb/tb_dpad_analog_ramp.sv
// Two DUTs (rest 0/step 1 and rest 128/step 3) share stimulus; every cycle is
// checked against an arithmetic model of the channel rules, plus directed scenarios.
module tb_dpad_analog_ramp;

  localparam int TD = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  mode;
  logic [1:0]  invert, inc, dec;
  logic [15:0] analog;
  logic [15:0] out_a, out_b;
  logic [1:0]  chg_a, chg_b;
  logic        tick_a, tick_b;

  always #5 clk = ~clk;

  dpad_analog_ramp #(.CHANNELS(2), .WIDTH(8), .TICK_DIV(TD), .STEP(1),
                     .MIN_VAL(0), .MAX_VAL(254), .REST_VAL(0)) dut_a (
    .clk_sys(clk), .reset(rst), .mode(mode), .invert(invert), .inc(inc), .dec(dec),
    .analog(analog), .out_val(out_a), .out_changed(chg_a), .tick(tick_a));

  dpad_analog_ramp #(.CHANNELS(2), .WIDTH(8), .TICK_DIV(TD), .STEP(3),
                     .MIN_VAL(0), .MAX_VAL(254), .REST_VAL(128)) dut_b (
    .clk_sys(clk), .reset(rst), .mode(mode), .invert(invert), .inc(inc), .dec(dec),
    .analog(analog), .out_val(out_b), .out_changed(chg_b), .tick(tick_b));

  int errors = 0;
  int checks = 0;

  // Stimulus, per channel
  int md[2];
  bit iv[2], ic[2], dc[2];
  int ain[2];

  // Reference state: [instance][channel]
  int rest_p[2] = '{0, 128};
  int step_p[2] = '{1, 3};
  int mv[2][2];
  int mcnt = 0;
  int nticks = 0;
  int obs_ticks = 0;
  int chg_a0 = 0;
  int chg_any_a = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int model_next(int v, int m, bit inv, bit i, bit d, int a,
                                    bit tk, int step, int rest);
    int u;
    if (m == 0) begin
      u = a + 128;
      if (inv) u = 255 - u;
      if (u > 254) u = 254;
      if (u < 0) u = 0;
      return u;
    end
    if (!tk) return v;
    if (i && !d) return (v + step > 254) ? 254 : v + step;
    if (d && !i) return (v - step < 0) ? 0 : v - step;
    if (i && d) return v;
    if (m == 2) begin
      if (v > rest) return (v - rest < step) ? rest : v - step;
      if (v < rest) return (rest - v < step) ? rest : v + step;
    end
    return v;
  endfunction

  task automatic step();
    bit tk;
    int nv;
    bit exp_chg[2][2];
    mode   = {md[1][1:0], md[0][1:0]};
    invert = {iv[1], iv[0]};
    inc    = {ic[1], ic[0]};
    dec    = {dc[1], dc[0]};
    analog = {ain[1][7:0], ain[0][7:0]};
    tk = (mcnt == TD - 1) && !rst;
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      for (int c = 0; c < 2; c++) begin
        if (rst) begin
          nv = rest_p[k];
          exp_chg[k][c] = 1'b0;
        end else begin
          nv = model_next(mv[k][c], md[c], iv[c], ic[c], dc[c], ain[c], tk,
                          step_p[k], rest_p[k]);
          exp_chg[k][c] = (nv != mv[k][c]);
        end
        mv[k][c] = nv;
      end
    end
    if (rst) mcnt = 0;
    else mcnt = (mcnt == TD - 1) ? 0 : mcnt + 1;
    if (tk) nticks++;
    #1;
    chk("tick_a", tick_a, (mcnt == TD - 1) && !rst);
    chk("tick_b", tick_b, (mcnt == TD - 1) && !rst);
    for (int c = 0; c < 2; c++) begin
      chk($sformatf("val_a%0d", c), out_a[c*8 +: 8], mv[0][c]);
      chk($sformatf("val_b%0d", c), out_b[c*8 +: 8], mv[1][c]);
      chk($sformatf("chg_a%0d", c), chg_a[c], exp_chg[0][c]);
      chk($sformatf("chg_b%0d", c), chg_b[c], exp_chg[1][c]);
    end
    if (tick_a) obs_ticks++;
    if (chg_a[0]) chg_a0++;
    if (chg_a != 2'b00) chg_any_a++;
  endtask

  task automatic run_ticks(input int n);
    int target;
    int guard;
    target = nticks + n;
    guard = 0;
    while (nticks < target && guard < n * TD + 10) begin
      step();
      guard++;
    end
    chk("tick_budget", nticks, target);
  endtask

  task automatic set_all(input int m, input bit i, input bit d, input int a);
    for (int c = 0; c < 2; c++) begin
      md[c] = m; ic[c] = i; dc[c] = d; ain[c] = a; iv[c] = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1;
    set_all(1, 0, 0, 0);

    // Reset, then idle in hold mode
    step();
    step();
    rst = 1'b0;
    obs_ticks = 0;
    chg_any_a = 0;
    for (int i = 0; i < 12; i++) step();
    chk("idle_val_a0", out_a[7:0], 0);
    chk("idle_ticks", obs_ticks, 3);
    chk("idle_changed", chg_any_a, 0);

    // Ramp up with inc held, saturate at MAX, then come down 10
    set_all(1, 1, 0, 0);
    chg_a0 = 0;
    run_ticks(254);
    chk("ramp_254", out_a[7:0], 254);
    run_ticks(46);
    chk("ramp_sat", out_a[7:0], 254);
    chk("ramp_pulses", chg_a0, 254);
    set_all(1, 0, 1, 0);
    run_ticks(10);
    chk("ramp_dec10", out_a[7:0], 244);

    // Spring-return on the rest=128/step=3 instance from 120
    set_all(0, 0, 0, -8);
    step();
    step();
    chk("spring_start", out_b[7:0], 120);
    set_all(2, 0, 0, -8);
    run_ticks(1);
    chk("spring_1", out_b[7:0], 123);
    run_ticks(1);
    chk("spring_2", out_b[7:0], 126);
    run_ticks(1);
    chk("spring_3", out_b[7:0], 128);
    run_ticks(2);
    chk("spring_hold", out_b[7:0], 128);

    // inc+dec together must not move the value
    set_all(0, 0, 0, 72);
    step();
    step();
    set_all(2, 1, 1, 72);
    run_ticks(3);
    chk("both_keys_a", out_a[7:0], 200);
    chk("both_keys_b", out_b[7:0], 200);

    // Analog passthrough and clamp
    set_all(0, 0, 0, -128);
    step();
    chk("an_min", out_a[7:0], 0);
    set_all(0, 0, 0, 0);
    step();
    chk("an_mid", out_a[7:0], 128);
    set_all(0, 0, 0, 127);
    step();
    chk("an_max_clamp", out_a[7:0], 254);
    set_all(0, 0, 0, -128);
    iv[0] = 1'b1; iv[1] = 1'b1;
    step();
    chk("an_invert_clamp", out_a[7:0], 254);

    // Bumpless switch from analog to ramp
    set_all(0, 0, 0, 100);
    step();
    chk("bump_analog", out_a[7:0], 228);
    set_all(1, 0, 1, 100);
    run_ticks(1);
    chk("bump_dec1", out_a[7:0], 227);
    run_ticks(1);
    chk("bump_dec2", out_a[7:0], 226);

    // Reset in the middle of a ramp at 77
    set_all(0, 0, 0, -51);
    step();
    chk("pre_reset_77", out_a[7:0], 77);
    set_all(1, 1, 0, -51);
    rst = 1'b1;
    step();
    chk("reset_val_a", out_a[7:0], 0);
    chk("reset_val_b", out_b[7:0], 128);
    rst = 1'b0;
    n = 0;
    do begin
      step();
      n++;
    end while (!tick_a && n < 20);
    chk("first_tick_delay", n, TD - 1);
    step();
    chk("post_reset_ramp_a", out_a[7:0], 1);
    chk("post_reset_ramp_b", out_b[7:0], 131);

    // Randomized soak against the reference model
    for (int i = 0; i < 600; i++) begin
      for (int c = 0; c < 2; c++) begin
        if ($urandom_range(0, 3) == 0) begin
          md[c]  = $urandom_range(0, 3);
          iv[c]  = 1'($urandom_range(0, 1));
          ic[c]  = 1'($urandom_range(0, 1));
          dc[c]  = ($urandom_range(0, 3) == 0);
          ain[c] = int'($urandom_range(0, 255)) - 128;
        end
      end
      rst = ($urandom_range(0, 63) == 0);
      step();
    end
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dpad_analog_ramp.md
Name: dpad_analog_ramp

Overview:
- Multi-channel controller-to-analog value generator for arcade cores with lever or paddle inputs (thrust, throttle, paddle).
- Each channel produces an unsigned WIDTH-bit value in one of three modes:
  - analog stick passthrough (offset-binary conversion, optional invert, clamp);
  - D-pad ramp with hold;
  - D-pad ramp with spring-return to a rest value.
- Sits between hps_io joystick outputs and the game core input ports; one instance serves all analog-style controls of a core.

Parameters:
- CHANNELS, 2, number of independent channels.
- WIDTH, 8, bit width of analog input and output value.
- TICK_DIV, 196850, clk_sys cycles per ramp step; must be >= 1.
- STEP, 1, amount added or subtracted per tick in ramp modes.
- MIN_VAL, 0, lower output clamp.
- MAX_VAL, 254, upper output clamp.
- REST_VAL, 0, reset value and spring-return target; MIN_VAL <= REST_VAL <= MAX_VAL.

Ports:
- clk_sys  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- mode  in  2*CHANNELS  per-channel mode: 0 analog, 1 ramp-hold, 2 ramp-spring, 3 reserved (behaves as 1).
- invert  in  CHANNELS  per-channel analog inversion.
- inc  in  CHANNELS  per-channel D-pad increase, level.
- dec  in  CHANNELS  per-channel D-pad decrease, level.
- analog  in  CHANNELS*WIDTH  per-channel signed two's-complement stick value.
- out_val  out  CHANNELS*WIDTH  per-channel unsigned value; channel n at [n*WIDTH +: WIDTH].
- out_changed  out  CHANNELS  one-cycle pulse when the channel's out_val changed on that edge.
- tick  out  1  one-cycle prescaler strobe.

Behaviour:
- Reset (sync, overrides all other activity on the same edge): prescaler=0, tick=0, every out_val=REST_VAL, out_changed=0.
- Prescaler: counts 0..TICK_DIV-1.
  - tick=1 for the cycle in which count==TICK_DIV-1; count then wraps to 0.
  - TICK_DIV=1 gives tick=1 every cycle after reset.
  - Shared by all channels.
- Analog mode (0): updates every cycle, 1-cycle registered latency.
  - u = analog + 2^(WIDTH-1), computed at WIDTH+1 bits.
  - If invert: u = (2^WIDTH - 1) - u.
  - out_val = clamp(u, MIN_VAL, MAX_VAL).
  - Examples (WIDTH=8): -128 -> 0; 0 -> 128; +127 -> 255, which clamps to MAX_VAL=254.
- Ramp modes (1, 2, 3): evaluated only on edges where tick=1; value holds between ticks.
  - inc only: out_val = min(out_val+STEP, MAX_VAL). Compute at WIDTH+1 bits; never wraps.
  - dec only: out_val = max(out_val-STEP, MIN_VAL). Compute signed; never underflows.
  - inc and dec together: no change.
  - Neither, mode 1 or 3: hold.
  - Neither, mode 2: move toward REST_VAL by STEP without overshoot; if |out_val-REST_VAL| < STEP, load REST_VAL.
- Mode switch is bumpless. The ramp accumulator and out_val are the same register, so entering a ramp mode continues from the last analog-mode value. Entering analog mode replaces the value on the next edge.
- mode and invert are sampled every cycle; a change takes effect on the next edge.
- out_changed[n] = 1 on the cycle after any edge on which out_val[n] took a new value. It is 0 if the value was recomputed but equal, including saturation at a clamp.
- Channels are fully independent; only the prescaler is shared.

Decomposition:
- Package dpad_analog_pkg:
  - typedef enum logic [1:0] ramp_mode_t {RM_ANALOG, RM_HOLD, RM_SPRING, RM_RSVD}.
  - Default localparams for WIDTH, MAX_VAL, TICK_DIV.
- Sub-module dpad_analog_chan: one channel (mode mux, clamp, spring logic, changed detect), instantiated CHANNELS times in a generate loop.
- Prescaler and port packing stay in the top module.

Test Plan (TICK_DIV=4, STEP=1, WIDTH=8, MIN=0, MAX=254, REST=0 unless stated):
- Reset then idle, mode=1 -> out_val=0 on all channels, tick every 4th cycle, out_changed never asserted.
- mode=1, inc held for 300 ticks -> value rises by 1 per tick, reaches 254 at tick 254 and stays there. out_changed pulses exactly 254 times. dec held 10 ticks -> 244.
- mode=2, REST_VAL=128, STEP=3, start 120 with no keys -> 123, 126, then 128, then holds. inc and dec together at 200 -> stays 200.
- mode=0, analog sequence -128, 0, 127 -> 0, 128, 254, each 1 cycle after input. invert=1 with analog=-128 -> 254 (255 clamped).
- mode=0 with analog=100 (out 228), then switch to mode=1 and hold dec for 2 ticks -> 227, 226, with no jump to 0.
- reset asserted mid-ramp at value 77 with inc held -> next edge out_val=0, prescaler restarts, first tick 4 cycles after reset deasserts.
